// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between the core's data-memory port
// (master) and a data-memory slave such as dmem_responder.
interface dmem_if #(
   parameter int ADDR_W = 10
);
   logic              req;
   logic              we;
   logic              bsel;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              ready;
   logic [31:0]       rdata;
   logic              err;

   modport master (
      output req, we, bsel, addr, wdata,
      input  ready, rdata, err
   );

   modport slave (
      input  req, we, bsel, addr, wdata,
      output ready, rdata, err
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated word/byte data memory for the multicycle core.
// One request at a time; the access commits WAIT_CYCLES edges after accept
// and ready pulses for one cycle afterwards.
// Build option: define DMEM_BYTE_EN to honour bsel (lb/sb). Without it every
// access is a word access and any non-zero addr[1:0] is flagged as err.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for req; captures the request at the accept edge
//   S_WAIT | counting down wait states; commits when cnt reaches zero
//   S_DONE | ready=1 for one cycle, rdata/err valid; back to S_IDLE
module dmem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input logic   clk,
   input logic   rst,
   dmem_if.slave bus
);
   localparam int         DEPTH    = 2 ** (ADDR_W - 2);
   localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic [31:0]       mem [DEPTH];

   logic              accept;
   logic              commit;
   logic              c_we;
   logic              c_byte;
   logic              misalign;
   logic [ADDR_W-1:0] c_addr;
   logic [ADDR_W-3:0] c_idx;
   logic [1:0]        c_lane;
   logic [31:0]       c_wdata;
   logic [31:0]       c_word;
   logic [7:0]        c_lb;
   logic [31:0]       c_rdata;

   assign accept = (state_q == S_IDLE) && bus.req;
   // With zero wait states the access commits on the accept edge itself.
   assign commit = (WAIT_CYCLES == 0) ? accept : ((state_q == S_WAIT) && (cnt_q == 4'd0));

   // At the accept edge the captured registers are not loaded yet, so a
   // zero-wait commit has to use the live request.
   assign c_we    = (state_q == S_IDLE) ? bus.we    : we_q;
   assign c_addr  = (state_q == S_IDLE) ? bus.addr  : addr_q;
   assign c_wdata = (state_q == S_IDLE) ? bus.wdata : wdata_q;

`ifdef DMEM_BYTE_EN
   logic bsel_q;
   assign c_byte = (state_q == S_IDLE) ? bus.bsel : bsel_q;

   // Byte-select capture, only needed when byte accesses exist.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         bsel_q <= 1'b0;
      else if (accept) bsel_q <= bus.bsel;
   end
`else
   logic unused_bsel;
   assign unused_bsel = bus.bsel;
   assign c_byte      = 1'b0;
`endif

   assign c_idx    = c_addr[ADDR_W-1:2];
   assign c_lane   = c_addr[1:0];
   assign c_word   = mem[c_idx];
   assign misalign = !c_byte && (c_lane != 2'b00);

   // Lane select and read-data formation for the access being committed.
   always_comb begin
      c_lb    = c_word[7:0];
      c_rdata = '0;
      case (c_lane)
         2'd1:    c_lb = c_word[15:8];
         2'd2:    c_lb = c_word[23:16];
         2'd3:    c_lb = c_word[31:24];
         default: c_lb = c_word[7:0];
      endcase
      if (!misalign && !c_we)
         c_rdata = c_byte ? {{24{c_lb[7]}}, c_lb} : c_word;
   end

   // Storage: no reset, written only by a successful write commit.
   always_ff @(posedge clk) begin
      if (commit && c_we && !misalign) begin
         if (c_byte) begin
            case (c_lane)
               2'd0: mem[c_idx][7:0]   <= c_wdata[7:0];
               2'd1: mem[c_idx][15:8]  <= c_wdata[7:0];
               2'd2: mem[c_idx][23:16] <= c_wdata[7:0];
               2'd3: mem[c_idx][31:24] <= c_wdata[7:0];
            endcase
         end else begin
            mem[c_idx] <= c_wdata;
         end
      end
   end

   // Next-state and wait counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               if (WAIT_CYCLES > 0) begin
                  cnt_d   = CNT_INIT;
                  state_d = S_WAIT;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) cnt_d   = cnt_q - 4'd1;
            else               state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, request capture and registered response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
         end
         if (commit) begin
            rdata_q <= c_rdata;
            err_q   <= misalign;
         end
      end
   end

   assign bus.ready = (state_q == S_DONE);
   assign bus.rdata = rdata_q;
   assign bus.err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state instance checked through an
// expected-response queue, a 0-wait instance for back-to-back throughput and
// a 4-wait instance for reset-in-flight behaviour.
module tb_dmem_responder;
`ifdef DMEM_BYTE_EN
   localparam bit BE = 1'b1;
`else
   localparam bit BE = 1'b0;
`endif

   logic clk;
   logic rst;
   logic rst4;
   int   cyc;
   int   n_checks;
   int   n_errors;

   typedef struct {
      logic [31:0] rd;
      logic        er;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   dmem_if #(.ADDR_W(10)) b2 ();
   dmem_if #(.ADDR_W(10)) b0 ();
   dmem_if #(.ADDR_W(10)) b4 ();

   dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst),  .bus(b2.slave));
   dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst),  .bus(b0.slave));
   dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(4)) dut4 (.clk(clk), .rst(rst4), .bus(b4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor for dut2: every ready pulse is matched against the queue.
   always @(negedge clk) begin
      if (b2.ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_ready", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rdata", b2.rdata, e.rd);
            chk("err", {31'd0, b2.err}, {31'd0, e.er});
            chk("latency_cyc", cyc, e.cyc);
         end
      end
   end

   // Issue one request to dut2; inputs are scrambled right after accept.
   task automatic issue(input logic we, input logic bs, input logic [9:0] a,
                        input logic [31:0] wd, input logic [31:0] erd, input logic eer);
      exp_t e;
      @(posedge clk); #1;
      b2.req = 1'b1; b2.we = we; b2.bsel = bs; b2.addr = a; b2.wdata = wd;
      @(posedge clk); #1;
      e.rd = erd; e.er = eer; e.cyc = cyc + 2;
      sb.push_back(e);
      b2.req = 1'b0; b2.addr = a ^ 10'h004; b2.wdata = ~wd;
      repeat (4) @(posedge clk);
   endtask

   // Run one access on dut4 and report the response and its latency.
   task automatic run4(input logic we, input logic [9:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e, output int lat);
      lat = -1; rd = '0; e = 1'b0;
      @(posedge clk); #1;
      b4.req = 1'b1; b4.we = we; b4.bsel = 1'b0; b4.addr = a; b4.wdata = wd;
      @(posedge clk); #1;
      b4.req = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (b4.ready === 1'b1) begin
            lat = n + 1; rd = b4.rdata; e = b4.err;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd;
      logic        e;
      int          lat;
      int          seen;
      int          pulses;
      logic        exp_rdy;

      n_checks = 0; n_errors = 0; cyc = 0;
      rst = 1'b1; rst4 = 1'b1;
      b2.req = 0; b2.we = 0; b2.bsel = 0; b2.addr = '0; b2.wdata = '0;
      b0.req = 0; b0.we = 0; b0.bsel = 0; b0.addr = '0; b0.wdata = '0;
      b4.req = 0; b4.we = 0; b4.bsel = 0; b4.addr = '0; b4.wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, b2.ready}, 32'd0);
      chk("rst_rdata", b2.rdata, 32'd0);
      chk("rst_err", {31'd0, b2.err}, 32'd0);
      chk("rst_ready4", {31'd0, b4.ready}, 32'd0);
      rst = 1'b0; rst4 = 1'b0;

      // dut2: directed vectors, expected responses pushed by issue()
      issue(1, 0, 10'h010, 32'hDEADBEEF, 32'h0, 0);
      issue(0, 0, 10'h010, 32'h0, 32'hDEADBEEF, 0);
      issue(1, 0, 10'h020, 32'h11223344, 32'h0, 0);
      issue(1, 1, 10'h021, 32'h00000080, 32'h0, !BE);
      issue(0, 0, 10'h020, 32'h0, BE ? 32'h11228044 : 32'h11223344, 0);
      issue(0, 1, 10'h021, 32'h0, BE ? 32'hFFFFFF80 : 32'h0, !BE);
      issue(0, 1, 10'h020, 32'h0, BE ? 32'h00000044 : 32'h11223344, 0);
      issue(1, 0, 10'h022, 32'h00000055, 32'h0, 1);
      issue(0, 0, 10'h020, 32'h0, BE ? 32'h11228044 : 32'h11223344, 0);
      issue(0, 0, 10'h013, 32'h0, 32'h0, 1);
      issue(1, 0, 10'h104, 32'h12345678, 32'h0, 0);
      issue(1, 0, 10'h100, 32'hA5A5A5A5, 32'h0, 0);
      issue(0, 0, 10'h104, 32'h0, 32'h12345678, 0);
      issue(0, 0, 10'h100, 32'h0, 32'hA5A5A5A5, 0);

      // dut0: seed a word, then hold req high for four reads
      @(posedge clk); #1;
      b0.req = 1; b0.we = 1; b0.addr = 10'h030; b0.wdata = 32'h0BADCAFE;
      @(posedge clk); #1;
      b0.req = 0;
      repeat (2) @(posedge clk);
      #1;
      b0.req = 1; b0.we = 0; b0.addr = 10'h030;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         exp_rdy = (i <= 6) && (i % 2 == 0);
         chk($sformatf("b2b_ready_%0d", i), {31'd0, b0.ready}, {31'd0, exp_rdy});
         if (b0.ready === 1'b1) begin
            pulses++;
            chk($sformatf("b2b_rdata_%0d", i), b0.rdata, 32'h0BADCAFE);
         end
         if (i == 6) b0.req = 0;
      end
      chk("b2b_pulses", pulses, 4);

      // dut4: reset during WAIT abandons the write
      run4(1, 10'h040, 32'h0, rd, e, lat);
      chk("w4_lat", lat, 4);
      chk("w4_err", {31'd0, e}, 32'd0);
      @(posedge clk); #1;
      b4.req = 1; b4.we = 1; b4.addr = 10'h040; b4.wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      b4.req = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst4 = 1'b1;
      #2 rst4 = 1'b0;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (b4.ready === 1'b1) seen++;
      end
      chk("rst_wait_no_ready", seen, 0);
      run4(0, 10'h040, 32'h0, rd, e, lat);
      chk("rst_wait_rdata", rd, 32'h0);
      chk("rst_wait_lat", lat, 4);

      // dut4: reset in DONE drops ready at once
      @(posedge clk); #1;
      b4.req = 1; b4.we = 0; b4.addr = 10'h040;
      @(posedge clk); #1;
      b4.req = 0;
      seen = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (b4.ready === 1'b1) begin
            seen = 1;
            break;
         end
      end
      chk("done_ready_seen", seen, 1);
      rst4 = 1'b1;
      #1;
      chk("done_rst_ready", {31'd0, b4.ready}, 32'd0);
      chk("done_rst_rdata", b4.rdata, 32'd0);
      #1 rst4 = 1'b0;
      run4(0, 10'h040, 32'h0, rd, e, lat);
      chk("after_done_rst_lat", lat, 4);
      chk("after_done_rst_rdata", rd, 32'h0);

      repeat (4) @(posedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
